xor_cipher_sequencer: RTL

//  Host-side controller for the serial XOR cipher core.
//  - Accepts a parallel key and message from the host, then drives the core's load_key, load_msg and en strobes.
//  - Serialises both operands into the core and collects the serial ciphertext back into a parallel word.
//  - Reports completion, or a timeout if the core never signals done. Sits between the host/register logic and the core.

---
 rtl/xor_seq_pkg.sv | 19 +
 rtl/xor_seq_piso.sv | 29 ++
 rtl/xor_cipher_sequencer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/xor_seq_pkg.sv
// Shared types and sizing helpers for the XOR cipher sequencer.
// The FSM state encoding and the counter width function live here.
package xor_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_KEY = 3'd1,
    LOAD_MSG = 3'd2,
    RUN      = 3'd3,
    DONE     = 3'd4,
    ERR      = 3'd5
  } state_t;

  // Bits needed to hold any count from 0 to maxVal inclusive.
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/xor_seq_piso.sv
// Parallel-in serial-out shift register, MSB first.
// oSerial always shows the bit that is currently due; iShift moves to the next.
module xor_seq_piso #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         iRst,
  input  logic         iLoad,
  input  logic         iShift,
  input  logic [W-1:0] iData,
  output logic         oSerial
);

  logic [W-1:0] shiftReg;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge iRst) begin
    if (!iRst) begin
      shiftReg <= '0;
    end else if (iLoad) begin
      shiftReg <= iData;
    end else if (iShift) begin
      shiftReg <= W'({shiftReg, 1'b0});
    end
  end

  assign oSerial = shiftReg[W-1];

endmodule

// File: rtl/xor_cipher_sequencer.sv
// Host-side controller for the serial XOR cipher core: loads key and message, collects ciphertext.
// Optional build macro XOR_SEQ_SELF_CHECK_EN adds oMismatch, a compare against msg ^ repeated key.
module xor_cipher_sequencer
  import xor_seq_pkg::*;
#(
  parameter int KEY_W   = 8,
  parameter int MSG_W   = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             iRst,
  input  logic [KEY_W-1:0] iKey,
  input  logic [MSG_W-1:0] iMsg,
  input  logic             iStart,
  output logic             oBusy,
  output logic [MSG_W-1:0] oResult,
  output logic             oResult_valid,
  output logic             oError,
  output logic             oCore_en,
  output logic             oCore_data,
  output logic             oCore_load_key,
  output logic             oCore_load_msg,
  input  logic             iCore_clk_slow,
  input  logic             iCore_data,
  input  logic             iCore_done
`ifdef XOR_SEQ_SELF_CHECK_EN
  ,
  output logic             oMismatch
`endif
);

  localparam int BIT_W = cntWidth((KEY_W > MSG_W) ? KEY_W : MSG_W);
  localparam int TO_W  = cntWidth(TIMEOUT);

  state_t           state;
  logic [BIT_W-1:0] bitCnt;
  logic [TO_W-1:0]  runCnt;
  logic             slowPrev;

  logic             loadOps;
  logic             keyBit;
  logic             msgBit;
  logic             slowEdge;
  logic             capture;
  logic             allCaptured;
  logic             timedOut;
  logic             enterDone;
  logic [MSG_W-1:0] resultNext;

  xor_seq_piso #(.W(KEY_W)) u_key_piso (
    .clk    (clk),
    .iRst   (iRst),
    .iLoad  (loadOps),
    .iShift (state == LOAD_KEY),
    .iData  (iKey),
    .oSerial(keyBit)
  );

  xor_seq_piso #(.W(MSG_W)) u_msg_piso (
    .clk    (clk),
    .iRst   (iRst),
    .iLoad  (loadOps),
    .iShift (state == LOAD_MSG),
    .iData  (iMsg),
    .oSerial(msgBit)
  );

  // Data line is gated by the registered strobes, so it is 0 whenever neither load is active.
  assign oCore_data = (oCore_load_key & keyBit) | (oCore_load_msg & msgBit);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    loadOps     = (state == IDLE) && iStart;
    slowEdge    = (state == RUN) && iCore_clk_slow && !slowPrev;
    capture     = slowEdge && (bitCnt < BIT_W'(MSG_W));
    resultNext  = oResult;
    if (capture) begin
      resultNext = MSG_W'({oResult, iCore_data});
    end
    allCaptured = (bitCnt == BIT_W'(MSG_W)) ||
                  (capture && (bitCnt == BIT_W'(MSG_W - 1)));
    timedOut    = (state == RUN) && (runCnt == TO_W'(TIMEOUT - 1));
    enterDone   = (state == RUN) && !timedOut && allCaptured && iCore_done;
  end

  always_ff @(posedge clk or negedge iRst) begin
    if (!iRst) begin
      state          <= IDLE;
      bitCnt         <= '0;
      runCnt         <= '0;
      slowPrev       <= 1'b0;
      oBusy          <= 1'b0;
      oResult        <= '0;
      oResult_valid  <= 1'b0;
      oError         <= 1'b0;
      oCore_en       <= 1'b0;
      oCore_load_key <= 1'b0;
      oCore_load_msg <= 1'b0;
    end else begin
      oResult_valid <= 1'b0;
      oError        <= 1'b0;
      case (state)
        IDLE: begin
          if (iStart) begin
            state          <= LOAD_KEY;
            oBusy          <= 1'b1;
            oCore_load_key <= 1'b1;
            bitCnt         <= '0;
            oResult        <= '0;
          end
        end
        LOAD_KEY: begin
          if (bitCnt == BIT_W'(KEY_W - 1)) begin
            state          <= LOAD_MSG;
            oCore_load_key <= 1'b0;
            oCore_load_msg <= 1'b1;
            bitCnt         <= '0;
          end else begin
            bitCnt <= bitCnt + BIT_W'(1);
          end
        end
        LOAD_MSG: begin
          if (bitCnt == BIT_W'(MSG_W - 1)) begin
            state          <= RUN;
            oCore_load_msg <= 1'b0;
            oCore_en       <= 1'b1;
            bitCnt         <= '0;
            runCnt         <= '0;
            slowPrev       <= 1'b0;
          end else begin
            bitCnt <= bitCnt + BIT_W'(1);
          end
        end
        RUN: begin
          slowPrev <= iCore_clk_slow;
          oResult  <= resultNext;
          if (capture) begin
            bitCnt <= bitCnt + BIT_W'(1);
          end
          // Timeout is tested first so it wins a tie with completion.
          if (timedOut) begin
            state    <= ERR;
            oCore_en <= 1'b0;
            oError   <= 1'b1;
          end else if (enterDone) begin
            state         <= DONE;
            oCore_en      <= 1'b0;
            oResult_valid <= 1'b1;
          end else begin
            runCnt <= runCnt + TO_W'(1);
          end
        end
        DONE, ERR: begin
          state    <= IDLE;
          oBusy    <= 1'b0;
          slowPrev <= 1'b0;
        end
        default: begin
          state          <= IDLE;
          oBusy          <= 1'b0;
          oCore_en       <= 1'b0;
          oCore_load_key <= 1'b0;
          oCore_load_msg <= 1'b0;
        end
      endcase
    end
  end

`ifdef XOR_SEQ_SELF_CHECK_EN
  logic [KEY_W-1:0] keyReg;
  logic [MSG_W-1:0] msgReg;
  logic [MSG_W-1:0] keyExpanded;

  for (genvar j = 0; j < MSG_W; j++) begin : g_key_rep
    assign keyExpanded[j] = keyReg[j % KEY_W];
  end

  // Compared against the result as it will stand in DONE, so the flag lines up with oResult_valid.
  always_ff @(posedge clk or negedge iRst) begin
    if (!iRst) begin
      keyReg    <= '0;
      msgReg    <= '0;
      oMismatch <= 1'b0;
    end else if (loadOps) begin
      keyReg    <= iKey;
      msgReg    <= iMsg;
      oMismatch <= 1'b0;
    end else if (enterDone) begin
      oMismatch <= (resultNext != (msgReg ^ keyExpanded));
    end
  end
`endif

endmodule
